ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the send direction paired with the existing PS/2 keyboard receiver.
- Lets the CPU side (via MIO_BUS) send command bytes to the keyboard: LED set 0xED, reset 0xFF, typematic 0xF3.
- Drives the open-drain PS2 clock/data lines through active-high pull-low enables.
- Reports completion and errors to the bus; asserts an inhibit flag so the receiver ignores bus activity while a transfer runs.

---
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte with an inhibit, request-to-send, shift and ack sequence.
// Latency: INHIBIT_CYCLES + SETUP_CYCLES + 11 device clock periods + idle wait, from tx_start to the done pulse.
// Backpressure: tx_start is accepted only in IDLE; requests made while busy are dropped, never queued.
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   tx_data, tx_start           byte to send and its one-cycle start request
//   busy, done                  transfer in progress / one-cycle completion pulse
//   ack_err, timeout_err        completion status, valid only while done is high
//   rx_inhibit                  tells the paired receiver to ignore line activity (equals busy)
//   ps2_clk_in, ps2_data_in     raw asynchronous line levels
//   ps2_clk_oe, ps2_data_oe     open-drain pull-low enables (1 = pull the line low)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int SETUP_CYCLES   = 500,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // One counter serves the inhibit/setup phases and the watchdog.
    localparam int CW = $clog2(INHIBIT_CYCLES + SETUP_CYCLES + TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            clk_s1, clk_s2;
    logic            data_s1, data_s2;
    logic            clk_filt;
    logic [FW-1:0]   filt_cnt;
    logic            fall;

    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [7:0]      tx_q;
    logic            par_q;
    logic            ack_err_q;
    logic            timeout_q;

    logic            watch;
    logic            wd_expire;
    logic [8:0]      frame;

    // Line synchronizers; idle lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Clock deglitch: the filtered level follows the synced level only after
    // FILTER_CYCLES consecutive differing samples. fall is a registered strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign watch     = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
    // A device edge in the same cycle as expiry counts as progress, not a timeout.
    assign wd_expire = watch && !fall && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign frame     = {par_q, tx_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tx_start) state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall && bit_cnt == 4'd9) state_nxt = S_ACK;
                else if (wd_expire)          state_nxt = S_DONE;
            end
            S_ACK: begin
                if (fall)           state_nxt = S_WAIT_IDLE;
                else if (wd_expire) state_nxt = S_DONE;
            end
            S_WAIT_IDLE: begin
                if (clk_filt && data_s2) state_nxt = S_DONE;
                else if (wd_expire)      state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: phase/watchdog counter, bit counter, captured byte and status latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_q      <= '0;
            par_q     <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_IDLE || state_nxt != state || (watch && fall)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == S_REQ) begin
                bit_cnt <= '0;
            end else if (state == S_SHIFT && fall) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == S_IDLE && tx_start) begin
                tx_q      <= tx_data;
                par_q     <= ~^tx_data;
                ack_err_q <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (state == S_ACK && fall) begin
                ack_err_q <= data_s2;
            end

            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        ack_err     = 1'b0;
        timeout_err = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            S_INHIBIT: begin
                busy       = 1'b1;
                ps2_clk_oe = 1'b1;
            end
            S_REQ: begin
                busy        = 1'b1;
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_SHIFT: begin
                busy = 1'b1;
                // n=0 keeps the start bit low; n=1..9 drive data LSB first then parity.
                if (bit_cnt == 4'd0) begin
                    ps2_data_oe = 1'b1;
                end else if (bit_cnt <= 4'd9) begin
                    ps2_data_oe = ~frame[bit_cnt - 4'd1];
                end
            end
            S_ACK, S_WAIT_IDLE: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done        = 1'b1;
                ack_err     = ack_err_q;
                timeout_err = timeout_q;
            end
            default: begin
            end
        endcase
    end

    assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int SET = 10;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, ack_err, timeout_err, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_line, ps2_data_line;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic last_ack = 1'b0;
    logic last_to = 1'b0;
    logic last_busy = 1'b0;

    logic [9:0] bits;
    int         base;
    int         k;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Completion monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            last_ack  <= ack_err;
            last_to   <= timeout_err;
            last_busy <= busy;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // Device model: waits for request-to-send, then generates npulses clock
    // pulses (40 clk low / 40 clk high). bits[i] records data_oe for n=i+1,
    // sampled late in each low phase. ack pulls data low during pulse 11.
    // glitch_pulse inserts a 5-cycle low blip in that pulse's high phase.
    task automatic dev_frame(input int npulses, input bit ack, input int glitch_pulse,
                             output logic [9:0] rec);
        int w;
        rec = '0;
        w = 0;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < 1000) begin
            tick();
            w++;
        end
        check("req_to_send_seen", (w < 1000) ? 1 : 0, 1);
        repeat (40) tick();
        for (int p = 1; p <= npulses; p++) begin
            dev_clk = 1'b0;
            if (p == 11 && ack) dev_data = 1'b0;
            repeat (40) tick();
            if (p <= 10) rec[4'(p - 1)] = ps2_data_oe;
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            if (p == glitch_pulse) begin
                repeat (20) tick();
                dev_clk = 1'b0;
                repeat (5) tick();
                dev_clk = 1'b1;
                repeat (15) tick();
            end else begin
                repeat (40) tick();
            end
        end
    endtask

    task automatic wait_done(input int start_cnt, input logic exp_ack, input string tag);
        int w;
        w = 0;
        while (done_cnt == start_cnt && w < 2000) begin
            tick();
            w++;
        end
        check({tag, "_done_count"}, done_cnt, start_cnt + 1);
        check({tag, "_ack_err"}, last_ack, exp_ack);
        check({tag, "_timeout_err"}, last_to, 1'b0);
        check({tag, "_busy_at_done"}, last_busy, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        rst = 1'b0;
        tick();
        check("idle_outputs", {busy, done, ack_err, timeout_err, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 7'b0);

        // 1: 0xED with ack
        base = done_cnt;
        send(8'hED);
        check("t1_busy_after_accept", {busy, rx_inhibit}, 2'b11);
        dev_frame(11, 1'b1, 0, bits);
        check("t1_bits_ED", bits, 10'h012);
        wait_done(base, 1'b0, "t1");

        // 2: 0x01, phase lengths and odd parity bit 0
        base = done_cnt;
        send(8'h01);
        k = 0;
        while (ps2_clk_oe && !ps2_data_oe && k < 1000) begin
            tick();
            k++;
        end
        check("t2_inhibit_cycles", k, INH);
        k = 0;
        while (ps2_clk_oe && ps2_data_oe && k < 1000) begin
            tick();
            k++;
        end
        check("t2_setup_cycles", k, SET);
        check("t2_clk_released_start_held", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        dev_frame(11, 1'b1, 0, bits);
        check("t2_bits_01", bits, 10'h1FE);
        wait_done(base, 1'b0, "t2");

        // 3: 0xFF, device does not ack
        base = done_cnt;
        send(8'hFF);
        dev_frame(11, 1'b0, 0, bits);
        check("t3_bits_FF", bits, 10'h000);
        wait_done(base, 1'b1, "t3");

        // 4: device never clocks -> watchdog
        base = done_cnt;
        send(8'hED);
        k = 0;
        while (ps2_clk_oe && k < 1000) begin
            tick();
            k++;
        end
        k = 0;
        while (!done && k < 6000) begin
            tick();
            k++;
        end
        check("t4_timeout_cycles", k, TMO);
        check("t4_status", {done, timeout_err, ack_err}, 3'b110);
        check("t4_lines_released", {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
        tick();
        check("t4_done_one_cycle", done, 0);
        check("t4_single_done", done_cnt, base + 1);

        // 5: start ignored while busy, and a clock glitch mid-frame
        base = done_cnt;
        send(8'hF3);
        repeat (20) tick();
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_frame(11, 1'b1, 4, bits);
        check("t5_bits_F3_glitch", bits, 10'h00C);
        wait_done(base, 1'b0, "t5");
        repeat (300) tick();
        check("t5_no_queued_transfer", {busy, ps2_clk_oe}, 2'b00);
        check("t5_one_done_pulse", done_cnt, base + 1);

        // 6: reset mid-frame at n=5, then a normal transfer
        base = done_cnt;
        send(8'hF3);
        dev_frame(5, 1'b0, 0, bits);
        check("t6_first_five_bits", bits[4:0], 5'b01100);
        rst = 1'b1;
        tick();
        check("t6_reset_releases", {busy, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 4'b0000);
        rst = 1'b0;
        repeat (50) tick();
        check("t6_no_done_on_reset", done_cnt, base);
        send(8'hED);
        dev_frame(11, 1'b1, 0, bits);
        check("t6_bits_after_reset", bits, 10'h012);
        wait_done(base, 1'b0, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
